data_mem: RTL
=============

Name: data_mem

Overview:
- Data-memory responder for the single-cycle core.
- Opposite end of the register file's memory interface: consumes read_mem/write_mem, addr and data_to_mem, and returns data_from_mem.
- Multi-cycle request/ready handshake with a parameterised wait-state count, so the core stalls until mem_ready.
- Supports RV32I byte/halfword/word loads (sign- and zero-extended) and stores, little-endian, with alignment and illegal-access detection.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words (power of two).
- WAIT_CYCLES, 1, wait states between accept and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset; asserted when 0.
- read_mem  input  1  load request (level).
- write_mem  input  1  store request (level).
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  32  byte address.
- data_to_mem  input  32  store data; low byte/half used for B/H.
- data_from_mem  output  32  load result, extended to 32 bits.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high while in WAIT or RESP.
- access_err  output  1  valid with mem_ready; misaligned or illegal access.

Behaviour:
- Reset (rst=0, any time):
  - State goes to IDLE.
  - data_from_mem=0, mem_ready=0, mem_busy=0, access_err=0.
  - Memory array is not cleared.
  - A pending store aborted by reset before its commit edge must not modify memory.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If read_mem|write_mem, capture addr, funct3, data_to_mem and the request type.
  - Next state is RESP if WAIT_CYCLES=0, else WAIT with cnt=WAIT_CYCLES-1.
  - Inputs are ignored outside IDLE; captured values are used throughout the access.
- WAIT: if cnt=0 go to RESP, else cnt decrements.
- Access edge (the edge entering RESP):
  - Store: write the enabled bytes to memory.
  - Load: register the extended result into data_from_mem.
- RESP: mem_ready=1 for exactly one cycle, then IDLE unconditionally.
- Latency: mem_ready is high in the cycle WAIT_CYCLES+1 after the request was first sampled in IDLE.
- Back-to-back: requester updates its request at the edge ending RESP. Back-to-back accesses therefore occur every WAIT_CYCLES+2 cycles, and the same request is never re-accepted.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Upper bits are ignored (wrap-around).
  - Byte lane = addr[1:0], little-endian.
- Loads:
  - B/H sign-extend bit 7/15; BU/HU zero-extend.
  - W returns the full word.
  - data_from_mem holds its value until the next completed access.
- Stores: SB writes lane addr[1:0]; SH writes lanes {addr[1],0}+{0,1}; SW writes all 4 lanes. Untouched bytes are preserved.
- access_err=1 in RESP, with no memory write and data_from_mem=0, if any of:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 in {011,110,111}.
  - A store with funct3[2]=1.
  - read_mem and write_mem both high when sampled.
- access_err is 0 otherwise and low outside RESP.
- mem_busy = (state!=IDLE).

Test Plan:
- Reset with rst=0 mid-WAIT of SW 0xDEADBEEF to addr 0x10 -> all outputs 0 and state IDLE; a later LW 0x10 does not return 0xDEADBEEF.
- WAIT_CYCLES=1: SW 0x11223344 to 0x20, then LW 0x20 -> each mem_ready pulse arrives 2 cycles after accept; data_from_mem=0x11223344, access_err=0.
- Following that, SB 0xAA to 0x21, then LB 0x21 -> 0xFFFFFFAA; LBU 0x21 -> 0x000000AA; LW 0x20 -> 0x1122AA44.
- SH 0x8001 to 0x22, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> 0x8001AA44.
- LW 0x21, SH 0x23, funct3=011 load, and read_mem=write_mem=1 -> each gives access_err=1 with mem_ready and data_from_mem=0; memory word 0x20 is unchanged.
- Wrap: DEPTH_WORDS=1024, SW 0x55 to addr 0x1000 -> LW 0x0 returns 0x55; WAIT_CYCLES=0 gives mem_ready one cycle after accept.

Source files
------------

// File: rtl/data_mem.sv
// Data-memory responder for the single-cycle core.
// Accepts a load/store request in IDLE, optionally waits WAIT_CYCLES cycles, performs the access
// on the edge entering RESP and pulses mem_ready for one cycle in RESP.
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-low reset
//   read_mem/write_mem - load / store request levels
//   funct3            - access size/sign (B, H, W, BU, HU)
//   addr, data_to_mem - byte address and store data
//   data_from_mem     - extended load result, held until the next completed access
//   mem_ready         - one-cycle completion pulse
//   mem_busy          - high while an access is in flight
//   access_err        - misaligned/illegal access flag, valid with mem_ready
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        access_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    // Upper address bits wrap around.
    logic unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr_q[31:AW+2]};

    // Live inputs in IDLE (so WAIT_CYCLES=0 can commit on the accept edge), captured values after.
    logic        cur_rd, cur_wr;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wdata;

    always_comb begin
        if (state_q == StIdle) begin
            cur_rd    = read_mem;
            cur_wr    = write_mem;
            cur_f3    = funct3;
            cur_addr  = addr;
            cur_wdata = data_to_mem;
        end else begin
            cur_rd    = rd_q;
            cur_wr    = wr_q;
            cur_f3    = f3_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    logic          req, accept, go_resp;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          acc_err;

    assign req    = read_mem | write_mem;
    assign accept = (state_q == StIdle) && req;
    assign widx   = cur_addr[AW+1:2];
    assign lane   = cur_addr[1:0];

    always_comb begin
        acc_err = 1'b0;
        if (cur_f3 inside {3'b011, 3'b110, 3'b111}) acc_err = 1'b1;
        if (cur_f3[1:0] == 2'b01 && lane[0])        acc_err = 1'b1;
        if (cur_f3[1:0] == 2'b10 && lane != 2'b00)  acc_err = 1'b1;
        if (cur_wr && cur_f3[2])                    acc_err = 1'b1;
        if (cur_rd && cur_wr)                       acc_err = 1'b1;
    end

    // Load extraction and extension.
    logic [31:0] rword, rshift, load_ext;
    assign rword  = mem[widx];
    assign rshift = rword >> {lane, 3'b000};

    always_comb begin
        load_ext = 32'h0;
        case (cur_f3)
            3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b010:  load_ext = rword;
            3'b100:  load_ext = {24'h0, rshift[7:0]};
            3'b101:  load_ext = {16'h0, rshift[15:0]};
            default: load_ext = 32'h0;
        endcase
    end

    // Store byte enables and lane-replicated data.
    logic [3:0]  be;
    logic [31:0] wbus;
    logic        mem_we;

    always_comb begin
        be   = 4'b0000;
        wbus = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                be   = 4'b0001 << lane;
                wbus = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be   = 4'b0011 << {lane[1], 1'b0};
                wbus = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                be   = 4'b1111;
                wbus = cur_wdata;
            end
            default: be = 4'b0000;
        endcase
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
                    cnt_d   = CNT_INIT;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign go_resp = (state_d == StResp) && (state_q != StResp);
    assign mem_we  = go_resp && cur_wr && !acc_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q    <= read_mem;
                wr_q    <= write_mem;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= data_to_mem;
            end
            if (go_resp) begin
                if (acc_err)     rdata_q <= 32'h0;
                else if (cur_rd) rdata_q <= load_ext;
            end
            // Only set on the edge entering RESP, so it is low everywhere else.
            err_q <= go_resp && acc_err;
        end
    end

    // Array is never cleared; gating on rst keeps a store aborted by reset from landing.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][i*8 +: 8] <= wbus[i*8 +: 8];
            end
        end
    end

    assign data_from_mem = rdata_q;
    assign mem_ready     = (state_q == StResp);
    assign mem_busy      = (state_q != StIdle);
    assign access_err    = err_q;

endmodule
